// File: rtl/fog_step_decimator.sv
// Averages 2^k signed step samples per window and queues the means in a FWFT FIFO.
// Define FOG_DEC_ERR_EN to add a lockstep error channel (i_err -> o_err_data).
module fog_step_decimator #(
  parameter int DEPTH = 8,
  parameter int MAX_K = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trig,
  input  logic [31:0] i_step,
`ifdef FOG_DEC_ERR_EN
  input  logic [31:0] i_err,
  output logic [31:0] o_err_data,
`endif
  input  logic [31:0] i_dec_sel,
  input  logic        i_ovf_clr,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic [6:0]  o_level,
  output logic        o_overflow
);
  localparam int AW = 32 + MAX_K;
  localparam int KW = (MAX_K < 1) ? 1 : $clog2(MAX_K + 1);
  localparam int CW = MAX_K + 1;
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_ADD  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_PUSH} state_t;

  // Reset asserts immediately but releases two clocks later, cleanly on i_clk.
  logic [1:0] rst_pipe_reg;
  logic       rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rst_pipe_reg <= 2'b11;
    else       rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
  end
  assign rst = rst_pipe_reg[1];

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc, n_cur;
  logic [KW-1:0]         k_cur, k_reg;
  logic signed [AW-1:0]  acc_reg;
  logic [1:0]            acc_op;
  logic                  push, k_chg;

  assign k_cur   = (i_dec_sel > 32'(MAX_K)) ? KW'(MAX_K) : i_dec_sel[KW-1:0];
  assign k_chg   = (k_cur != k_reg);
  assign n_cur   = CW'(1) << k_cur;
  assign cnt_inc = cnt_reg + 1'b1;

  function automatic logic signed [AW-1:0] acc_apply(input logic [1:0] op,
                                                     input logic signed [AW-1:0] acc,
                                                     input logic [31:0] s);
    logic signed [AW-1:0] ext;
    ext = {{MAX_K{s[31]}}, s};
    case (op)
      OP_CLR:  acc_apply = '0;
      OP_LOAD: acc_apply = ext;
      OP_ADD:  acc_apply = acc + ext;
      default: acc_apply = acc;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_op     = OP_HOLD;
    push       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_trig) begin
          acc_op     = OP_LOAD;
          cnt_next   = CW'(1);
          state_next = (n_cur == CW'(1)) ? S_PUSH : S_ACC;
        end
      end
      S_ACC: begin
        if (k_chg) begin
          acc_op   = OP_CLR;
          cnt_next = '0;
          if (i_trig) begin
            acc_op   = OP_LOAD;
            cnt_next = CW'(1);
            if (n_cur == CW'(1)) state_next = S_PUSH;
          end
        end else if (i_trig) begin
          acc_op   = OP_ADD;
          cnt_next = cnt_inc;
          if (cnt_inc == n_cur) state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        // A completed window is written even if k moves this cycle.
        push       = 1'b1;
        acc_op     = OP_CLR;
        cnt_next   = '0;
        state_next = S_ACC;
        if (i_trig) begin
          acc_op   = OP_LOAD;
          cnt_next = CW'(1);
          if (n_cur == CW'(1)) state_next = S_PUSH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_apply(acc_op, acc_reg, i_step);
      k_reg     <= k_cur;
    end
  end

  // FIFO: memory body plus a registered head word; o_level counts both.
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   mem_cnt_reg;
  logic [31:0]   wr_data;
  logic          pop, wr_en, ld;

  assign wr_data = 32'(acc_reg >>> k_reg);
  assign pop     = o_valid & i_ready;
  assign o_level = 7'(mem_cnt_reg) + 7'(o_valid);
  assign wr_en   = push & ((o_level < 7'(DEPTH)) | pop);
  assign ld      = (mem_cnt_reg != '0) & (~o_valid | pop);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      mem_cnt_reg <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (ld) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        o_data     <= mem[rd_ptr_reg];
      end
      case ({wr_en, ld})
        2'b10:   mem_cnt_reg <= mem_cnt_reg + 1'b1;
        2'b01:   mem_cnt_reg <= mem_cnt_reg - 1'b1;
        default: mem_cnt_reg <= mem_cnt_reg;
      endcase
      if (ld)       o_valid <= 1'b1;
      else if (pop) o_valid <= 1'b0;
      if (push && !wr_en) o_overflow <= 1'b1;
      else if (i_ovf_clr) o_overflow <= 1'b0;
    end
  end

`ifdef FOG_DEC_ERR_EN
  logic signed [AW-1:0] acc_err_reg;
  logic [31:0]          mem_err [DEPTH];

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) acc_err_reg <= '0;
    else     acc_err_reg <= acc_apply(acc_op, acc_err_reg, i_err);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_err[wr_ptr_reg] <= 32'(acc_err_reg >>> k_reg);
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)     o_err_data <= '0;
    else if (ld) o_err_data <= mem_err[rd_ptr_reg];
  end
`endif

endmodule

// File: tb/tb_fog_step_decimator.sv
// Directed and random stimulus for fog_step_decimator, scored against a window-mean model.
module tb_fog_step_decimator;
  localparam int DEPTH = 8;
  localparam int MAX_K = 10;

  logic        i_clk = 1'b0;
  logic        i_rst, i_trig, i_ovf_clr, i_ready;
  logic [31:0] i_step, i_dec_sel;
  logic [31:0] o_data;
  logic        o_valid, o_overflow;
  logic [6:0]  o_level;

  int     total = 0;
  int     bad = 0;
  int     exp_q[$];
  longint win_sum = 0;
  int     win_cnt = 0;
  int     cur_k = 0;
  int     n_popped = 0;
  bit     exp_ovf = 1'b0;
  int     p0;

  fog_step_decimator #(.DEPTH(DEPTH), .MAX_K(MAX_K)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_trig(i_trig), .i_step(i_step),
    .i_dec_sel(i_dec_sel), .i_ovf_clr(i_ovf_clr), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_level(o_level), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_k(input logic [31:0] sel);
    return (sel > 32'(MAX_K)) ? MAX_K : int'(sel);
  endfunction

  // Mean rounded toward minus infinity, by division with correction.
  function automatic int floor_mean(input longint s, input int k);
    longint n = 1;
    longint q;
    for (int i = 0; i < k; i++) n = n * 2;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_sample(input int v);
    win_sum += v;
    win_cnt++;
    if (win_cnt == (1 << cur_k)) begin
      if (!i_ready && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(floor_mean(win_sum, cur_k));
      win_sum = 0;
      win_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic trig(input int v);
    i_trig = 1'b1;
    i_step = v;
    model_sample(v);
    tick();
    i_trig = 1'b0;
  endtask

  task automatic set_sel(input logic [31:0] sel);
    int nk;
    i_dec_sel = sel;
    nk = clamp_k(sel);
    if (nk != cur_k) begin
      win_sum = 0;
      win_cnt = 0;
    end
    cur_k = nk;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    repeat (2) tick();
    check("drain_done", exp_q.size(), 0);
  endtask

  always @(negedge i_clk) begin
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      check("out_pending", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("out_data", $signed(o_data), exp_q.pop_front());
        n_popped++;
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_trig = 1'b0; i_step = '0; i_ovf_clr = 1'b0; i_ready = 1'b1;
    i_dec_sel = 32'd2; cur_k = 2;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", $signed(o_data), 0);
    check("rst_level", o_level, 0);
    check("rst_ovf", o_overflow, 0);
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (4) tick();

    // four-sample window, latency of the result
    set_sel(2); tick();
    p0 = n_popped;
    trig(10); trig(20); trig(30); trig(41);
    check("lat_t0_valid", o_valid, 0);
    tick(); check("lat_t1_valid", o_valid, 0);
    tick(); check("lat_t2_valid", o_valid, 1);
    check("lat_t2_data", $signed(o_data), 25);
    tick(); check("lat_single_pulse", o_valid, 0);
    check("lat_one_result", n_popped, p0 + 1);

    // negative mean floors
    set_sel(1); tick();
    trig(-3); trig(-4);
    tick(); tick();
    check("floor_neg_data", $signed(o_data), -4);
    tick();

    // exponent above MAX_K clamps
    set_sel(40); tick();
    p0 = n_popped;
    repeat (1023) trig(int'($urandom));
    repeat (3) tick();
    check("k40_no_early", n_popped, p0);
    trig(int'($urandom));
    repeat (3) tick();
    check("k40_one_result", n_popped, p0 + 1);

    // fill past capacity with consumer stalled
    set_sel(0); tick();
    i_ready = 1'b0; tick();
    for (int i = 0; i < 10; i++) trig(100 + i);
    repeat (3) tick();
    check("full_level", o_level, DEPTH);
    check("full_ovf", o_overflow, 1);
    check("full_ovf_model", o_overflow, exp_ovf);
    check("full_head", $signed(o_data), 100);
    repeat (3) tick();
    check("full_head_hold", $signed(o_data), 100);
    check("full_valid_hold", o_valid, 1);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    check("ovf_cleared", o_overflow, 0);
    trig(200);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    check("ovf_set_wins", o_overflow, 1);
    check("full_level_after_drop", o_level, DEPTH);
    // write at full level is accepted when a pop lands the same cycle
    i_trig = 1'b1; i_step = 300; tick(); i_trig = 1'b0;
    i_ready = 1'b1; exp_q.push_back(300);
    tick();
    check("full_pop_accept_level", o_level, DEPTH);
    wait_drain();
    check("drained_level", o_level, 0);
    check("ovf_sticky", o_overflow, 1);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    check("ovf_clear2", o_overflow, 0);

    // exponent change discards the partial window
    set_sel(3); tick();
    p0 = n_popped;
    repeat (5) trig(1000);
    set_sel(2); tick();
    trig(1); trig(2); trig(3); trig(6);
    tick(); tick();
    check("kchg_valid", o_valid, 1);
    check("kchg_data", $signed(o_data), 3);
    tick();
    check("kchg_one_result", n_popped, p0 + 1);

    // back-to-back triggers
    set_sel(0); tick();
    p0 = n_popped;
    for (int i = 0; i < 20; i++) trig(i * 7 - 50);
    repeat (3) tick();
    check("b2b_k0_count", n_popped, p0 + 20);
    set_sel(2); tick();
    p0 = n_popped;
    for (int i = 0; i < 16; i++) trig(i * 13 - 90);
    repeat (3) tick();
    check("b2b_k2_count", n_popped, p0 + 4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0: set_sel(0);
          1: set_sel(1);
          2: set_sel(2);
          3: set_sel(3);
          default: set_sel(45 + $urandom_range(0, 1000));
        endcase
      end
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) trig(int'($urandom_range(0, 200000)) - 100000);
      else tick();
    end
    i_ready = 1'b1;
    wait_drain();
    check("rand_no_ovf", o_overflow, 0);

    // reset mid-window with words queued
    set_sel(2); tick();
    i_ready = 1'b0;
    repeat (8) trig(int'($urandom_range(0, 5000)));
    repeat (3) tick();
    check("pre_rst_level", o_level, 2);
    repeat (3) trig(77);
    i_rst = 1'b1;
    exp_q.delete(); win_sum = 0; win_cnt = 0;
    #1;
    check("rst2_valid", o_valid, 0);
    check("rst2_data", $signed(o_data), 0);
    check("rst2_level", o_level, 0);
    check("rst2_ovf", o_overflow, 0);
    tick(); tick();
    i_rst = 1'b0;
    repeat (4) tick();
    i_ready = 1'b1;
    p0 = n_popped;
    trig(5); trig(6); trig(7); trig(8);
    tick(); tick();
    check("post_rst_data", $signed(o_data), 6);
    tick();
    check("post_rst_count", n_popped, p0 + 1);

    repeat (3) tick();
    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fog_step_decimator.md
FOG_STEP_DECIMATOR -- requirements
Module: fog_step_decimator

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in words (power of 2, 2..64).
REQ-002 SHALL have parameter MAX_K, default 10, largest decimation exponent.
REQ-003 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_trig  input  1  one-cycle sample strobe (step-sync pulse from the loop stage).
REQ-006 SHALL have port i_step  input  32  signed feedback-step sample, valid when i_trig=1.
REQ-007 SHALL have port i_dec_sel  input  32  decimation exponent k; N=2^k samples per window.
REQ-008 SHALL have port i_ovf_clr  input  1  clears o_overflow.
REQ-009 SHALL have port i_ready  input  1  consumer (CPU bridge) accepts o_data.
REQ-010 SHALL have port o_data  output  32  signed window mean at FIFO head.
REQ-011 SHALL have port o_valid  output  1  o_data valid; transfer when o_valid&i_ready.
REQ-012 SHALL have port o_level  output  7  current FIFO occupancy.
REQ-013 SHALL have port o_overflow  output  1  sticky: a window result was dropped.

Function
REQ-014 SHALL use k=min(i_dec_sel,MAX_K); values above MAX_K clamp to MAX_K.
REQ-015 SHALL implement FSM IDLE->ACC->PUSH->ACC; IDLE only after reset.
REQ-016 IDLE: on first i_trig SHALL load acc=sign-extended i_step, cnt=1, go ACC (PUSH directly if N=1).
REQ-017 ACC: each i_trig SHALL add sign-extended i_step into 32+MAX_K-bit acc and increment cnt; when cnt reaches N SHALL go PUSH.
REQ-018 PUSH (one cycle): SHALL write acc>>>k (arithmetic, truncation toward -inf, low 32 bits) into FIFO, clear acc/cnt, return ACC.
REQ-019 An i_trig arriving during PUSH SHALL start the next window (acc=sample, cnt=1); no sample lost.
REQ-020 Latency: window-completing i_trig at cycle T -> FIFO write at T+1 -> o_valid=1 at T+2 when FIFO was empty.
REQ-021 A change of clamped k, registered each cycle, SHALL discard the partial window (acc=0, cnt=0) without writing; an i_trig in that cycle starts the new window.
REQ-022 FIFO write SHALL be accepted when level<DEPTH, or when level=DEPTH and a pop occurs the same cycle.
REQ-023 A rejected write SHALL be dropped and set o_overflow=1; o_overflow holds until i_ovf_clr; simultaneous set and clear -> set wins.
REQ-024 FIFO SHALL be first-word-fall-through, o_data registered; o_data SHALL hold stable while o_valid&!i_ready.
REQ-025 Pop on empty SHALL be impossible (o_valid=0); o_level SHALL never exceed DEPTH or underflow.

Reset
REQ-026 i_rst SHALL asynchronously force FSM=IDLE, acc=0, cnt=0, FIFO pointers=0, o_data=0, o_valid=0, o_level=0, o_overflow=0.
REQ-027 Reset asserted mid-window or with FIFO non-empty SHALL discard all content; first post-reset i_trig starts a fresh window.
REQ-028 Release SHALL be synchronised internally (2-flop) so deassertion is clean on i_clk.

Configuration
REQ-029 Macro FOG_DEC_ERR_EN, when defined, SHALL add ports i_err (input 32 signed) and o_err_data (output 32 signed), accumulated/averaged/queued in lockstep with i_step, sharing FSM, FIFO pointers and handshake.
REQ-030 Without FOG_DEC_ERR_EN those ports and their storage SHALL be absent; all other behaviour identical.

Verification
REQ-031 k=2, i_step=10,20,30,41 on 4 triggers, i_ready=1 -> one o_valid pulse, o_data=25, two cycles after 4th trigger.
REQ-032 k=1, i_step=-3,-4 -> o_data=-4 (arithmetic floor of -7/2); k=40 -> behaves as k=10 (1024 triggers per result).
REQ-033 DEPTH=8, k=0, i_ready=0, 10 triggers -> o_level=8, o_overflow=1, o_data=first sample held; i_ready=1 then drains 8 words in order; i_ovf_clr -> o_overflow=0.
REQ-034 k=3, 5 triggers, then i_dec_sel=2 -> no write; next 4 triggers -> one result = mean of those 4 only.
REQ-035 Triggers back-to-back every cycle, k=0 -> one result per trigger, none lost, correct order.
REQ-036 i_rst pulse after 3 of 4 samples with 2 words queued -> outputs 0; next 4 triggers produce exactly one correct result.
